// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  // Fetch sequencer states
  localparam logic [2:0] StBoot    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StHold    = 3'd2;
  localparam logic [2:0] StDiscard = 3'd3;
  localparam logic [2:0] StAdErr   = 3'd4;

  // Sequential PC step, wrapping modulo 2^32
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Holds a fetched word and its PC while ID is stalled.
module if_hold_buf (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Clear wins over load so a redirect always drops the buffered word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      pc    <= '0;
      instr <= '0;
    end else if (load) begin
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the imem handshake, tracks the PC and
// feeds IF/ID with delivery, stall, flush and delay-slot information.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        id_is_branch,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_redirect,
  input  logic [31:0] exc_vector,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCOut,
  output logic [31:0] PCAdd4,
  output logic        IF_Stall,
  output logic        IF_Flush,
  output logic        IF_IsBDS,
  output logic        IF_EXC_AdIF
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic [31:0] redir_q, redir_d;
  logic        aligned, in_fetch, in_hold, deliver, hold_load;
  logic [31:0] hold_pc, hold_instr, pc_after;

  assign aligned   = (pc_q[1:0] == 2'b00);
  assign in_fetch  = (state_q == StFetch);
  assign in_hold   = (state_q == StHold);
  // DISCARD keeps the old request alive until memory completes it
  assign imem_req  = (in_fetch && aligned) || (state_q == StDiscard);
  assign imem_addr = pc_q;
  assign hold_load = in_fetch && aligned && imem_ack && id_stall && !exc_redirect;
  // A branch resolved in the delivery cycle is newer than any pending one
  assign pc_after  = br_taken ? br_target : (br_pend_q ? br_tgt_q : pc_plus4(pc_q));

  // Decide whether a slot is handed to IF/ID this cycle
  always_comb begin
    deliver = 1'b0;
    if (!exc_redirect && !id_stall) begin
      case (state_q)
        StFetch: deliver = aligned ? imem_ack : 1'b1;
        StHold:  deliver = 1'b1;
        default: deliver = 1'b0;
      endcase
    end
  end

  // Next state, PC and deferred redirect target
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    case (state_q)
      StBoot: begin
        state_d = StFetch;
        if (exc_redirect) pc_d = exc_vector;
      end
      StFetch: begin
        if (exc_redirect) begin
          if (aligned && !imem_ack) begin
            state_d = StDiscard;
            redir_d = exc_vector;
          end else begin
            pc_d = exc_vector;
          end
        end else if (!aligned) begin
          if (deliver) state_d = StAdErr;
        end else if (hold_load) begin
          state_d = StHold;
        end else if (deliver) begin
          pc_d = pc_after;
        end
      end
      StHold: begin
        if (exc_redirect) begin
          state_d = StFetch;
          pc_d    = exc_vector;
        end else if (deliver) begin
          state_d = StFetch;
          pc_d    = pc_after;
        end
      end
      StDiscard: begin
        if (imem_ack) begin
          state_d = StFetch;
          pc_d    = exc_redirect ? exc_vector : redir_q;
        end else if (exc_redirect) begin
          redir_d = exc_vector;
        end
      end
      StAdErr: begin
        if (exc_redirect) begin
          state_d = StFetch;
          pc_d    = exc_vector;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Single-entry pending branch, consumed by the next delivery
  always_comb begin
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    if (exc_redirect) begin
      br_pend_d = 1'b0;
    end else if (deliver) begin
      br_pend_d = 1'b0;
    end else if (br_taken) begin
      br_pend_d = 1'b1;
      br_tgt_d  = br_target;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StBoot;
      pc_q      <= RESET_VECTOR;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
      redir_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
      redir_q   <= redir_d;
    end
  end

  if_hold_buf u_if_hold_buf (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (hold_load),
    .clear    (exc_redirect),
    .pc_in    (pc_q),
    .instr_in (imem_rdata),
    .pc       (hold_pc),
    .instr    (hold_instr)
  );

  // IF/ID-facing outputs; reset_n gating keeps them quiet while in reset
  always_comb begin
    IF_Instruction = '0;
    if (in_fetch && aligned) IF_Instruction = imem_rdata;
    else if (in_hold)        IF_Instruction = hold_instr;
    IF_PCOut    = in_hold ? hold_pc : pc_q;
    PCAdd4      = IF_PCOut + 32'd4;
    IF_Stall    = reset_n && id_stall;
    IF_Flush    = !reset_n || exc_redirect || (!id_stall && !deliver);
    IF_IsBDS    = deliver && id_is_branch;
    IF_EXC_AdIF = deliver && in_fetch && !aligned;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: scripted cycle table, reset checks and a
// randomized run against a delivered-stream reference model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        id_is_branch;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_redirect;
  logic [31:0] exc_vector;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PCOut;
  logic [31:0] PCAdd4;
  logic        IF_Stall;
  logic        IF_Flush;
  logic        IF_IsBDS;
  logic        IF_EXC_AdIF;

  fetch_sequencer #(
    .RESET_VECTOR (32'hBFC0_0000)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .id_is_branch   (id_is_branch),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .exc_redirect   (exc_redirect),
    .exc_vector     (exc_vector),
    .IF_Instruction (IF_Instruction),
    .IF_PCOut       (IF_PCOut),
    .PCAdd4         (PCAdd4),
    .IF_Stall       (IF_Stall),
    .IF_Flush       (IF_Flush),
    .IF_IsBDS       (IF_IsBDS),
    .IF_EXC_AdIF    (IF_EXC_AdIF)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        ack;
    logic        stall;
    logic        isb;
    logic        bt;
    logic [31:0] bta;
    logic        exr;
    logic [31:0] exv;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] pc;
    logic        bds;
    logic        adif;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic stall, input logic isb,
                              input logic bt, input logic [31:0] bta, input logic exr,
                              input logic [31:0] exv, input logic req,
                              input logic [31:0] addr, input logic flush,
                              input logic [31:0] pc, input logic bds, input logic adif);
    vec_t v;
    v = '{ack, stall, isb, bt, bta, exr, exv, req, addr, flush, pc, bds, adif};
    return v;
  endfunction

  localparam int NV = 25;
  vec_t vt [NV];

  // Random-phase reference model state
  logic [31:0] exp_pc, ptgt, out_addr, nxt;
  logic        pend, had_out, delivered;
  int          ndel;

  initial begin
    // ack stall isb bt bta exr exv | req addr flush pc bds adif
    vt[0]  = mk(0,0,0,0,0,0,0,                   0,32'hBFC0_0000,1,0,0,0);
    vt[1]  = mk(1,0,0,0,0,0,0,                   1,32'hBFC0_0000,0,32'hBFC0_0000,0,0);
    vt[2]  = mk(1,0,0,0,0,0,0,                   1,32'hBFC0_0004,0,32'hBFC0_0004,0,0);
    vt[3]  = mk(1,0,1,1,32'h100,0,0,             1,32'hBFC0_0008,0,32'hBFC0_0008,1,0);
    vt[4]  = mk(1,0,0,0,0,0,0,                   1,32'h100,0,32'h100,0,0);
    vt[5]  = mk(1,0,1,1,32'h200,0,0,             1,32'h104,0,32'h104,1,0);
    vt[6]  = mk(0,0,0,1,32'h10,0,0,              1,32'h200,1,0,0,0);
    vt[7]  = mk(1,0,0,0,0,0,0,                   1,32'h200,0,32'h200,0,0);
    vt[8]  = mk(1,1,0,0,0,0,0,                   1,32'h10,0,0,0,0);
    vt[9]  = mk(0,1,0,0,0,0,0,                   0,32'h10,0,0,0,0);
    vt[10] = mk(0,1,0,0,0,0,0,                   0,32'h10,0,0,0,0);
    vt[11] = mk(0,0,0,0,0,0,0,                   0,32'h10,0,32'h10,0,0);
    vt[12] = mk(1,0,0,0,0,0,0,                   1,32'h14,0,32'h14,0,0);
    vt[13] = mk(0,0,0,0,0,1,32'h8000_0180,       1,32'h18,1,0,0,0);
    vt[14] = mk(0,0,0,0,0,0,0,                   1,32'h18,1,0,0,0);
    vt[15] = mk(1,0,0,0,0,0,0,                   1,32'h18,1,0,0,0);
    vt[16] = mk(1,0,1,1,32'hFFFF_FFFC,0,0,       1,32'h8000_0180,0,32'h8000_0180,1,0);
    vt[17] = mk(1,0,0,0,0,0,0,                   1,32'hFFFF_FFFC,0,32'hFFFF_FFFC,0,0);
    vt[18] = mk(1,0,1,1,32'h203,0,0,             1,32'h0,0,32'h0,1,0);
    vt[19] = mk(0,0,0,0,0,0,0,                   0,32'h203,0,32'h203,0,1);
    vt[20] = mk(0,0,0,0,0,0,0,                   0,32'h203,1,0,0,0);
    vt[21] = mk(1,0,0,0,0,0,0,                   0,32'h203,1,0,0,0);
    vt[22] = mk(0,0,0,0,0,1,32'h300,             0,32'h203,1,0,0,0);
    vt[23] = mk(1,0,0,0,0,1,32'h400,             1,32'h300,1,0,0,0);
    vt[24] = mk(1,0,0,0,0,0,0,                   1,32'h400,0,32'h400,0,0);

    // Reset state, with id_stall high to show IF_Stall is masked
    reset_n = 1'b0;
    imem_ack = 0; id_stall = 1; id_is_branch = 0; br_taken = 0; br_target = '0;
    exc_redirect = 0; exc_vector = '0;
    #12;
    check1("rst imem_req", imem_req, 1'b0);
    check32("rst imem_addr", imem_addr, 32'hBFC0_0000);
    check32("rst IF_Instruction", IF_Instruction, 32'h0);
    check32("rst IF_PCOut", IF_PCOut, 32'hBFC0_0000);
    check32("rst PCAdd4", PCAdd4, 32'hBFC0_0004);
    check1("rst IF_Stall", IF_Stall, 1'b0);
    check1("rst IF_Flush", IF_Flush, 1'b1);
    check1("rst IF_IsBDS", IF_IsBDS, 1'b0);
    check1("rst IF_EXC_AdIF", IF_EXC_AdIF, 1'b0);

    @(posedge clock); #1;
    reset_n = 1'b1;

    // Scripted cycle table; row 0 is the BOOT cycle
    for (int i = 0; i < NV; i++) begin
      imem_ack = vt[i].ack; id_stall = vt[i].stall; id_is_branch = vt[i].isb;
      br_taken = vt[i].bt; br_target = vt[i].bta;
      exc_redirect = vt[i].exr; exc_vector = vt[i].exv;
      @(negedge clock);
      check1($sformatf("v%0d imem_req", i), imem_req, vt[i].req);
      check32($sformatf("v%0d imem_addr", i), imem_addr, vt[i].addr);
      check1($sformatf("v%0d IF_Flush", i), IF_Flush, vt[i].flush);
      check1($sformatf("v%0d IF_Stall", i), IF_Stall, vt[i].stall);
      if (!vt[i].flush && !vt[i].stall) begin
        check32($sformatf("v%0d IF_PCOut", i), IF_PCOut, vt[i].pc);
        check32($sformatf("v%0d PCAdd4", i), PCAdd4, vt[i].pc + 32'd4);
        check32($sformatf("v%0d IF_Instruction", i), IF_Instruction,
                vt[i].adif ? 32'h0 : mem_word(vt[i].pc));
        check1($sformatf("v%0d IF_IsBDS", i), IF_IsBDS, vt[i].bds);
        check1($sformatf("v%0d IF_EXC_AdIF", i), IF_EXC_AdIF, vt[i].adif);
      end
      @(posedge clock); #1;
    end

    // Reset asserted mid-fetch: request drops at once, a late ack is ignored
    imem_ack = 0; id_stall = 0; id_is_branch = 0; br_taken = 0;
    exc_redirect = 0;
    check1("midrst req before", imem_req, 1'b1);
    check32("midrst addr before", imem_addr, 32'h404);
    reset_n = 1'b0;
    #1;
    check1("midrst req async", imem_req, 1'b0);
    check32("midrst addr async", imem_addr, 32'hBFC0_0000);
    #1 imem_ack = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check1("boot req", imem_req, 1'b0);
    check1("boot flush", IF_Flush, 1'b1);
    @(posedge clock); #1;
    @(negedge clock);
    check32("first fetch addr", imem_addr, 32'hBFC0_0000);
    check1("first fetch flush", IF_Flush, 1'b0);
    check32("first fetch instr", IF_Instruction, mem_word(32'hBFC0_0000));

    // Randomized run: delivered stream must follow PC+4 / branch / redirect rules
    exp_pc = 32'hBFC0_0004; pend = 1'b0; ptgt = '0; ndel = 0; had_out = 1'b0;
    out_addr = '0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clock); #1;
      id_stall     = ($urandom_range(0, 3) == 0);
      imem_ack     = imem_req && ($urandom_range(0, 2) != 0);
      id_is_branch = 1'($urandom_range(0, 1));
      br_taken     = ($urandom_range(0, 6) == 0);
      br_target    = $urandom & 32'hFFFF_FFFC;
      exc_redirect = ($urandom_range(0, 39) == 0);
      exc_vector   = $urandom & 32'hFFFF_FFFC;
      @(negedge clock);
      delivered = !IF_Flush && !id_stall;
      check1("rand IF_Stall", IF_Stall, id_stall);
      if (exc_redirect) check1("rand redirect flush", IF_Flush, 1'b1);
      if (had_out) begin
        check1("rand req held", imem_req, 1'b1);
        check32("rand addr stable", imem_addr, out_addr);
      end
      if (delivered) begin
        check32("rand IF_PCOut", IF_PCOut, exp_pc);
        check32("rand IF_Instruction", IF_Instruction, mem_word(exp_pc));
        check32("rand PCAdd4", PCAdd4, exp_pc + 32'd4);
        check1("rand IF_IsBDS", IF_IsBDS, id_is_branch);
        ndel++;
        nxt    = br_taken ? br_target : (pend ? ptgt : exp_pc + 32'd4);
        exp_pc = nxt;
        pend   = 1'b0;
      end else if (exc_redirect) begin
        exp_pc = exc_vector;
        pend   = 1'b0;
      end else if (br_taken) begin
        pend = 1'b1;
        ptgt = br_target;
      end
      had_out  = imem_req && !imem_ack;
      out_addr = imem_addr;
    end
    check1("rand progress", ndel >= 300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 imem_req  output  1  fetch request, held high with imem_addr stable until imem_ack.
REQ-005 imem_addr  output  32  fetch address, always equal to the current PC register.
REQ-006 imem_ack  input  1  request completes this cycle (same cycle as imem_req allowed); imem_rdata valid.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 id_stall  input  1  IF/ID must hold its contents this cycle.
REQ-009 id_is_branch  input  1  ID holds a branch or jump.
REQ-010 br_taken  input  1  taken branch or jump in ID; br_target is valid.
REQ-011 br_target  input  32  branch or jump destination.
REQ-012 exc_redirect  input  1  exception or ERET redirect from a later stage.
REQ-013 exc_vector  input  32  redirect destination.
REQ-014 IF_Instruction  output  32  instruction offered to IF/ID.
REQ-015 IF_PCOut  output  32  PC of IF_Instruction.
REQ-016 PCAdd4  output  32  IF_PCOut + 4.
REQ-017 IF_Stall  output  1  IF/ID holds.
REQ-018 IF_Flush  output  1  IF/ID loads a bubble.
REQ-019 IF_IsBDS  output  1  offered instruction is a branch delay slot.
REQ-020 IF_EXC_AdIF  output  1  offered slot carries an address-error-on-fetch exception.

Function
REQ-021 States: BOOT, FETCH, HOLD, DISCARD, ADERR.
REQ-022 BOOT lasts exactly one cycle after reset release, then goes to FETCH; no imem_req in BOOT.
REQ-023 FETCH: imem_req=1 while PC[1:0]==0; on imem_ack the word is delivered (deliver=1) in that same cycle; PC advances at the clock edge.
REQ-024 With imem_ack every cycle and no stall, throughput is one instruction per cycle; ack-to-delivery latency is 0 cycles.
REQ-025 Ack while id_stall=1: capture rdata/PC into a hold buffer, go to HOLD; HOLD offers the buffer and returns to FETCH on the first cycle id_stall=0 (deliver=1 in that cycle).
REQ-026 IF_Stall = id_stall; IF_Flush = !id_stall && !deliver.
REQ-027 IF_IsBDS = deliver && id_is_branch && !id_stall.
REQ-028 Next PC after a delivery: pending branch target if one is recorded or br_taken is asserted this cycle, else PC+4 (modulo 2^32, wraps).
REQ-029 br_taken in a cycle without delivery is recorded as pending (one entry; a newer br_taken overwrites it) and is applied at the next delivery.
REQ-030 exc_redirect has highest priority in every state: PC <= exc_vector, pending branch cleared, hold buffer dropped, IF_Flush=1 that cycle.
REQ-031 exc_redirect while imem_req is outstanding without imem_ack: go to DISCARD; keep the old address on imem_addr until ack, drop that word, then re-enter FETCH at the new PC.
REQ-032 PC[1:0]!=0 in FETCH: no imem_req; go to ADERR; deliver once with IF_Instruction=0 and IF_EXC_AdIF=1; then remain idle with IF_Flush=1 until exc_redirect.
REQ-033 Simultaneous exc_redirect and imem_ack: the word is dropped and the fetch at exc_vector issues next cycle.

Reset
REQ-034 While reset_n=0: PC=RESET_VECTOR, state=BOOT, imem_req=0, IF_Instruction=0, IF_PCOut=RESET_VECTOR, PCAdd4=RESET_VECTOR+4, IF_Stall=0, IF_Flush=1, IF_IsBDS=0, IF_EXC_AdIF=0; pending branch and hold buffer cleared.
REQ-035 Assertion mid-fetch drops imem_req asynchronously; any later ack for that request is ignored.

Structure
REQ-036 The state enum and RESET_VECTOR default live in the shared CPU package.
REQ-037 The hold buffer is the sole sub-module, if_hold_buf (PC and instruction register with load and clear).
REQ-038 Outputs connect to the IF interface signals of the same names.

Verification
REQ-039 Reset release, ack every cycle -> imem_addr BFC00000, BFC00004, BFC00008 on consecutive cycles starting the cycle after BOOT; IF_Flush=0.
REQ-040 Branch in ID at PC 0x100 with br_taken and target 0x200 -> word from 0x104 delivered with IF_IsBDS=1; next imem_addr=0x200.
REQ-041 id_stall held 3 cycles during ack of 0x10 -> IF_Stall=1 for 3 cycles, then 0x10 delivered once; no duplicate and no loss.
REQ-042 exc_redirect to 0x80000180 with ack pending 2 cycles -> old word dropped; next request is 0x80000180.
REQ-043 Jump target 0x203 -> no imem_req; one slot with IF_EXC_AdIF=1 and IF_Instruction=0; then idle until exc_redirect.
REQ-044 PC 0xFFFFFFFC delivered -> next imem_addr=0x00000000.
